// File: rtl/serial_pattern_source.sv
// -----------------------------------------------------------------------------
// serial_pattern_source
//
// Upstream feeder for the serial sequence detector. Parallel words arrive over
// a valid/ready handshake and are buffered in a small circular FIFO. Each word
// is shifted out MSB-first on `x`, one bit per clock. Between words, `x` holds
// IDLE_BIT, and an optional fixed gap of GAP idle cycles follows every word.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   din        parallel word to serialize (WIDTH bits)
//   din_valid  din is valid this cycle
//   din_ready  FIFO can accept a word (== !full, no bypass on full)
//   x          registered serial bit stream, MSB of each word first
//   busy       registered, high while shifting a word or inserting the gap
//   word_done  registered one-cycle pulse, high while a word's LSB is on x
//   level      FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module serial_pattern_source #(
  parameter int unsigned WIDTH    = 8,     // 2..16
  parameter int unsigned DEPTH    = 4,     // power of two, 2..16
  parameter logic        IDLE_BIT = 1'b1,
  parameter int unsigned GAP      = 0      // 0..15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic                     x,
  output logic                     busy,
  output logic                     word_done,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [CW-1:0] CNT_LOAD   = CW'(WIDTH - 1);
  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);
  localparam bit            HAS_GAP    = (GAP != 0);
  // Gap counter counts GAP-1 down to 0, so the gap lasts exactly GAP cycles.
  localparam logic [3:0]    GAP_LOAD   = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [3:0]       gap_cnt;
  logic [WIDTH-1:0] head;
  logic             push;
  logic             pop;
  logic             last_bit;

  // Full blocks pushes even when a pop happens on the same edge (no bypass).
  assign din_ready = (level != FULL_LEVEL);
  assign push      = din_valid && din_ready;
  assign head      = mem[rd_ptr];
  assign last_bit  = (cnt == '0);

  // Pop decisions use the registered level, i.e. the occupancy before any
  // push landing on the same edge; such a word is picked up one cycle later.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    pop = 1'b0;
    case (state)
      ST_IDLE:  pop = (level != '0);
      ST_SHIFT: pop = last_bit && !HAS_GAP && (level != '0);
      ST_GAP:   pop = (gap_cnt == 4'd0) && (level != '0);
      default:  pop = 1'b0;
    endcase
  end

  // NOTE: the FIFO storage array has no reset; pointers and level define
  // which entries are valid, so clearing the data itself buys nothing.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;  // wraps modulo DEPTH
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      cnt       <= '0;
      gap_cnt   <= '0;
      x         <= IDLE_BIT;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (pop) begin
        // Load from IDLE, from the end of a gap, or back-to-back from SHIFT.
        state <= ST_SHIFT;
        shreg <= head;
        x     <= head[WIDTH-1];
        cnt   <= CNT_LOAD;
        busy  <= 1'b1;
      end else begin
        case (state)
          ST_SHIFT: begin
            if (!last_bit) begin
              shreg     <= {shreg[WIDTH-2:0], 1'b0};
              x         <= shreg[WIDTH-2];
              cnt       <= cnt - 1'b1;
              // Next bit on x is the LSB exactly when the count reaches 0.
              word_done <= (cnt == CW'(1));
            end else if (HAS_GAP) begin
              state   <= ST_GAP;
              gap_cnt <= GAP_LOAD;
              x       <= IDLE_BIT;
            end else begin
              state <= ST_IDLE;
              x     <= IDLE_BIT;
              busy  <= 1'b0;
            end
          end
          ST_GAP: begin
            x <= IDLE_BIT;
            if (gap_cnt != 4'd0) begin
              gap_cnt <= gap_cnt - 4'd1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
          ST_IDLE: begin
            x    <= IDLE_BIT;
            busy <= 1'b0;
          end
          default: begin
            // Unreachable encoding: recover to a clean idle line.
            state <= ST_IDLE;
            x     <= IDLE_BIT;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_pattern_source.sv
// -----------------------------------------------------------------------------
// tb_serial_pattern_source
//
// Two instances: dut_a (GAP=0) drives the scoreboard monitor and most scenarios,
// dut_b (GAP=3) covers the inter-word gap. Words accepted by dut_a are queued
// and compared against the bits reassembled from x while busy is high.
// -----------------------------------------------------------------------------
module tb_serial_pattern_source;

  logic       clk;
  logic       rst;
  logic [7:0] din_a, din_b;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b;
  logic       x_a, x_b;
  logic       busy_a, busy_b;
  logic       wd_a, wd_b;
  logic [2:0] level_a, level_b;

  int         tests_run    = 0;
  int         tests_failed = 0;

  logic [7:0] exp_q [$];
  int         bitcnt  = 0;
  logic [7:0] sb_word = '0;
  logic [7:0] sb_exp;
  bit         mon_en  = 1'b0;

  serial_pattern_source #(
    .WIDTH(8), .DEPTH(4), .IDLE_BIT(1'b1), .GAP(0)
  ) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(valid_a),
    .din_ready(ready_a), .x(x_a), .busy(busy_a), .word_done(wd_a),
    .level(level_a)
  );

  serial_pattern_source #(
    .WIDTH(8), .DEPTH(4), .IDLE_BIT(1'b1), .GAP(3)
  ) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(valid_b),
    .din_ready(ready_b), .x(x_b), .busy(busy_b), .word_done(wd_b),
    .level(level_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor for dut_a: reassemble words from x while busy.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (busy_a) begin
        tests_run++;
        if (wd_a !== (bitcnt == 7)) begin
          tests_failed++;
          $display("FAIL sb_word_done: got %b expected %b (bit %0d)", wd_a, (bitcnt == 7), bitcnt);
        end
        sb_word = {sb_word[6:0], x_a};
        bitcnt++;
        if (bitcnt == 8) begin
          bitcnt = 0;
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_unexpected_word: got %h expected none", sb_word);
          end else begin
            sb_exp = exp_q.pop_front();
            if (sb_word !== sb_exp) begin
              tests_failed++;
              $display("FAIL sb_word: got %h expected %h", sb_word, sb_exp);
            end
          end
        end
      end else begin
        tests_run++;
        if (x_a !== 1'b1 || wd_a !== 1'b0) begin
          tests_failed++;
          $display("FAIL sb_idle: got x=%b wd=%b expected x=1 wd=0", x_a, wd_a);
        end
      end
    end
  end

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mon_en  = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    din_a   = '0;
    din_b   = '0;
    rst     = 1'b1;
    next_edge();
    next_edge();
    @(negedge clk);
    tests_run++;
    if ({x_a, ready_a, busy_a, wd_a, level_a} !== {1'b1, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      tests_failed++;
      $display("FAIL reset_a: got x/rdy/busy/wd/lvl=%b%b%b%b/%0d expected 1100/0",
               x_a, ready_a, busy_a, wd_a, level_a);
    end
    tests_run++;
    if ({x_b, ready_b, busy_b, wd_b, level_b} !== {1'b1, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      tests_failed++;
      $display("FAIL reset_b: got x/rdy/busy/wd/lvl=%b%b%b%b/%0d expected 1100/0",
               x_b, ready_b, busy_b, wd_b, level_b);
    end
    rst = 1'b0;
    next_edge();
    exp_q.delete();
    bitcnt = 0;
    mon_en = 1'b1;
  endtask

  // Single word 8'h1A: bits 0,0,0,1,1,0,1,0 after one idle cycle.
  task automatic test_single();
    logic [7:0] w   = 8'h1A;
    logic [6:0] det = '0;
    logic       hit;
    din_a   = w;
    valid_a = 1'b1;
    exp_q.push_back(w);
    next_edge();
    valid_a = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k == 0) begin
        tests_run++;
        if (x_a !== 1'b1 || busy_a !== 1'b0 || level_a !== 3'd1) begin
          tests_failed++;
          $display("FAIL single_pushed: got x=%b busy=%b lvl=%0d expected x=1 busy=0 lvl=1",
                   x_a, busy_a, level_a);
        end
      end else if (k <= 8) begin
        det = {det[5:0], x_a};
        hit = (det == 7'b0011010);
        tests_run++;
        if (x_a !== w[8-k] || busy_a !== 1'b1) begin
          tests_failed++;
          $display("FAIL single_bit%0d: got x=%b busy=%b expected x=%b busy=1", k, x_a, busy_a, w[8-k]);
        end
        tests_run++;
        if (wd_a !== (k == 8) || hit !== (k == 8)) begin
          tests_failed++;
          $display("FAIL single_done%0d: got wd=%b det=%b expected %b", k, wd_a, hit, (k == 8));
        end
      end else begin
        tests_run++;
        if (x_a !== 1'b1 || busy_a !== 1'b0 || level_a !== 3'd0) begin
          tests_failed++;
          $display("FAIL single_end: got x=%b busy=%b lvl=%0d expected x=1 busy=0 lvl=0",
                   x_a, busy_a, level_a);
        end
      end
      next_edge();
    end
  endtask

  // Four words on consecutive cycles, GAP=0: 32 contiguous data bits.
  task automatic test_burst();
    logic [7:0]  words [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    logic [31:0] stream    = 32'hA53CFF00;
    int          k;
    int          exp_lvl;
    for (int c = 0; c < 36; c++) begin
      k = c - 1;
      if (c < 4) begin
        din_a   = words[c];
        valid_a = 1'b1;
        exp_q.push_back(words[c]);
      end else begin
        valid_a = 1'b0;
      end
      @(negedge clk);
      if (c < 4) begin
        tests_run++;
        if (ready_a !== 1'b1) begin
          tests_failed++;
          $display("FAIL burst_ready%0d: got %b expected 1", c, ready_a);
        end
      end
      if (k >= 1 && k <= 32) begin
        tests_run++;
        if (x_a !== stream[32-k] || busy_a !== 1'b1 || wd_a !== ((k % 8) == 0)) begin
          tests_failed++;
          $display("FAIL burst_bit%0d: got x=%b busy=%b wd=%b expected x=%b busy=1 wd=%b",
                   k, x_a, busy_a, wd_a, stream[32-k], ((k % 8) == 0));
        end
      end
      case (k)
        3:       exp_lvl = 3;
        9:       exp_lvl = 2;
        17:      exp_lvl = 1;
        25:      exp_lvl = 0;
        default: exp_lvl = -1;
      endcase
      if (exp_lvl >= 0) begin
        tests_run++;
        if (level_a !== 3'(exp_lvl)) begin
          tests_failed++;
          $display("FAIL burst_level%0d: got %0d expected %0d", k, level_a, exp_lvl);
        end
      end
      if (k == 33) begin
        tests_run++;
        if (busy_a !== 1'b0 || x_a !== 1'b1 || level_a !== 3'd0) begin
          tests_failed++;
          $display("FAIL burst_end: got busy=%b x=%b lvl=%0d expected busy=0 x=1 lvl=0",
                   busy_a, x_a, level_a);
        end
      end
      next_edge();
    end
  endtask

  // din_valid held high with incrementing data; refused words never appear.
  task automatic test_backpressure();
    logic [7:0] data     = 8'h40;
    int         accepted = 0;
    int         rejected = 0;
    int         t;
    for (int c = 0; c < 70; c++) begin
      din_a   = data;
      valid_a = 1'b1;
      @(negedge clk);
      tests_run++;
      if (ready_a !== (level_a != 3'd4)) begin
        tests_failed++;
        $display("FAIL bp_ready: got %b expected %b (lvl=%0d)", ready_a, (level_a != 3'd4), level_a);
      end
      if (ready_a === 1'b1) begin
        exp_q.push_back(data);
        accepted++;
      end else begin
        rejected++;
      end
      data = data + 8'd1;
      next_edge();
    end
    valid_a = 1'b0;
    t = 0;
    while (t < 200 && (exp_q.size() != 0 || busy_a !== 1'b0)) begin
      next_edge();
      t++;
    end
    tests_run++;
    if (exp_q.size() != 0 || busy_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_drain: got %0d words pending busy=%b expected 0 pending busy=0", exp_q.size(), busy_a);
    end
    tests_run++;
    if (accepted < 10 || rejected == 0) begin
      tests_failed++;
      $display("FAIL bp_coverage: got accepted=%0d rejected=%0d expected >=10 and >0", accepted, rejected);
    end
    tests_run++;
    if (level_a !== 3'd0) begin
      tests_failed++;
      $display("FAIL bp_level: got %0d expected 0", level_a);
    end
  endtask

  // GAP=3 instance: 81, three idle cycles, 7E, word_done 11 cycles apart.
  task automatic test_gap();
    logic [21:0] exp_x = {8'h81, 3'b111, 8'h7E, 3'b111};
    int          k;
    int          first_wd = -1;
    int          last_wd  = -1;
    int          n_wd     = 0;
    for (int c = 0; c < 25; c++) begin
      k = c - 1;
      if (c < 2) begin
        din_b   = (c == 0) ? 8'h81 : 8'h7E;
        valid_b = 1'b1;
      end else begin
        valid_b = 1'b0;
      end
      @(negedge clk);
      if (c < 2) begin
        tests_run++;
        if (ready_b !== 1'b1) begin
          tests_failed++;
          $display("FAIL gap_ready%0d: got %b expected 1", c, ready_b);
        end
      end
      if (wd_b === 1'b1) begin
        if (first_wd < 0) first_wd = k;
        last_wd = k;
        n_wd++;
      end
      if (k >= 1 && k <= 22) begin
        tests_run++;
        if (x_b !== exp_x[22-k] || busy_b !== 1'b1 || wd_b !== (k == 8 || k == 19)) begin
          tests_failed++;
          $display("FAIL gap_cycle%0d: got x=%b busy=%b wd=%b expected x=%b busy=1 wd=%b",
                   k, x_b, busy_b, wd_b, exp_x[22-k], (k == 8 || k == 19));
        end
      end
      if (k == 23) begin
        tests_run++;
        if (busy_b !== 1'b0 || x_b !== 1'b1 || level_b !== 3'd0) begin
          tests_failed++;
          $display("FAIL gap_end: got busy=%b x=%b lvl=%0d expected busy=0 x=1 lvl=0",
                   busy_b, x_b, level_b);
        end
      end
      next_edge();
    end
    tests_run++;
    if (n_wd != 2 || (last_wd - first_wd) != 11) begin
      tests_failed++;
      $display("FAIL gap_spacing: got %0d pulses %0d apart expected 2 pulses 11 apart",
               n_wd, last_wd - first_wd);
    end
  endtask

  // Reset after 3 bits of 1A with two more words buffered.
  task automatic test_reset_mid();
    logic [7:0] words [3] = '{8'h1A, 8'h55, 8'h33};
    int         k;
    mon_en = 1'b0;
    for (int c = 0; c < 36; c++) begin
      k = c - 1;
      if (c < 3) begin
        din_a   = words[c];
        valid_a = 1'b1;
      end else begin
        valid_a = 1'b0;
      end
      rst = (c == 4);
      @(negedge clk);
      if (k >= 1 && k <= 3) begin
        tests_run++;
        if (x_a !== words[0][8-k]) begin
          tests_failed++;
          $display("FAIL rmid_bit%0d: got %b expected %b", k, x_a, words[0][8-k]);
        end
      end
      if (k == 3) begin
        tests_run++;
        if (level_a !== 3'd2) begin
          tests_failed++;
          $display("FAIL rmid_buffered: got %0d expected 2", level_a);
        end
      end
      if (k == 4) begin
        tests_run++;
        if ({x_a, level_a, busy_a, ready_a} !== {1'b1, 3'd0, 1'b0, 1'b1}) begin
          tests_failed++;
          $display("FAIL rmid_after_reset: got x=%b lvl=%0d busy=%b rdy=%b expected x=1 lvl=0 busy=0 rdy=1",
                   x_a, level_a, busy_a, ready_a);
        end
      end
      if (k >= 5) begin
        tests_run++;
        if (x_a !== 1'b1 || busy_a !== 1'b0 || wd_a !== 1'b0) begin
          tests_failed++;
          $display("FAIL rmid_quiet%0d: got x=%b busy=%b wd=%b expected x=1 busy=0 wd=0",
                   k, x_a, busy_a, wd_a);
        end
      end
      next_edge();
    end
    rst = 1'b0;
    exp_q.delete();
    bitcnt = 0;
    mon_en = 1'b1;
  endtask

  // Push lands on the edge that ends the last bit of the final buffered word.
  task automatic test_push_on_last();
    logic [7:0] w0 = 8'h3C;
    logic [7:0] w1 = 8'hC5;
    int         k;
    for (int c = 0; c < 20; c++) begin
      k = c - 1;
      if (c == 0) begin
        din_a   = w0;
        valid_a = 1'b1;
        exp_q.push_back(w0);
      end else if (c == 9) begin
        din_a   = w1;
        valid_a = 1'b1;
        exp_q.push_back(w1);
      end else begin
        valid_a = 1'b0;
      end
      @(negedge clk);
      if (k >= 1 && k <= 8) begin
        tests_run++;
        if (x_a !== w0[8-k] || wd_a !== (k == 8)) begin
          tests_failed++;
          $display("FAIL pol_first%0d: got x=%b wd=%b expected x=%b wd=%b", k, x_a, wd_a, w0[8-k], (k == 8));
        end
      end
      if (k == 8) begin
        tests_run++;
        if (ready_a !== 1'b1 || level_a !== 3'd0) begin
          tests_failed++;
          $display("FAIL pol_last_bit: got rdy=%b lvl=%0d expected rdy=1 lvl=0", ready_a, level_a);
        end
      end
      if (k == 9) begin
        tests_run++;
        if (x_a !== 1'b1 || busy_a !== 1'b0 || level_a !== 3'd1) begin
          tests_failed++;
          $display("FAIL pol_idle_gap: got x=%b busy=%b lvl=%0d expected x=1 busy=0 lvl=1",
                   x_a, busy_a, level_a);
        end
      end
      if (k >= 10 && k <= 17) begin
        tests_run++;
        if (x_a !== w1[17-k] || busy_a !== 1'b1 || wd_a !== (k == 17)) begin
          tests_failed++;
          $display("FAIL pol_second%0d: got x=%b busy=%b wd=%b expected x=%b busy=1 wd=%b",
                   k, x_a, busy_a, wd_a, w1[17-k], (k == 17));
        end
      end
      if (k == 18) begin
        tests_run++;
        if (x_a !== 1'b1 || busy_a !== 1'b0 || level_a !== 3'd0) begin
          tests_failed++;
          $display("FAIL pol_end: got x=%b busy=%b lvl=%0d expected x=1 busy=0 lvl=0",
                   x_a, busy_a, level_a);
        end
      end
      next_edge();
    end
  endtask

  initial begin
    rst     = 1'b1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    din_a   = '0;
    din_b   = '0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_gap();
    test_reset_mid();
    test_push_on_last();
    mon_en = 1'b0;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_leftover: got %0d words never seen expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
